// File: rtl/core_run_ctrl.sv
// Core run controller: boot sequencing, RUN accounting and halt detection (idle loops, external halt, timeout).
// Define RUN_CTRL_LOOP2_EN to compile in the two-instruction loop detector.
module core_run_ctrl #(
   parameter int BOOT_CYCLES   = 2,
   parameter int STABLE_THRESH = 3,
   parameter int LOOP2_THRESH  = 4,
   parameter int MAX_CYCLES    = 2000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        halt_req,
   input  logic [31:0] pc_current,
   input  logic [31:0] instruction_current,
   input  logic        stall,
   output logic        core_reset,
   output logic        core_enable,
   output logic [1:0]  state,
   output logic        halted,
   output logic [1:0]  halt_cause,
   output logic [31:0] cycle_count,
   output logic [31:0] instr_count,
   output logic [31:0] loop_pc
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BOOT = 2'd1,
      S_RUN  = 2'd2,
      S_HALT = 2'd3
   } state_t;

   state_t      cur_st, nxt_st;
   logic [31:0] boot_cnt;
   logic [31:0] prev_pc, prev_instr, rep_cnt, rep_inc;
   logic        hist1;
   logic [31:0] cyc_inc, ins_inc;
   logic        instr_valid, single_hit, loop2_hit, timeout_hit;
   logic        halt_any, enter_boot;
   logic [1:0]  cause_sel;

   always_comb begin
      cyc_inc     = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;
      ins_inc     = (instr_count == 32'hFFFF_FFFF) ? instr_count : instr_count + 32'd1;
      instr_valid = (instruction_current != 32'h0000_0013) && !stall;
      rep_inc     = (hist1 && pc_current == prev_pc && instruction_current == prev_instr)
                    ? rep_cnt + 32'd1 : 32'd0;
      single_hit  = (rep_inc != 32'd0) && (rep_inc == 32'(STABLE_THRESH));
      timeout_hit = (cyc_inc == 32'(MAX_CYCLES));
      halt_any    = halt_req || single_hit || loop2_hit || timeout_hit;
      if (halt_req)        cause_sel = 2'd0;
      else if (single_hit) cause_sel = 2'd1;
      else if (loop2_hit)  cause_sel = 2'd2;
      else                 cause_sel = 2'd3;
   end

`ifdef RUN_CTRL_LOOP2_EN
   logic [31:0] pc_d2, m_cnt, m_inc;
   logic [1:0]  hist2;

   always_comb begin
      m_inc     = (hist2 == 2'd2 && pc_current == pc_d2) ? m_cnt + 32'd1 : 32'd0;
      loop2_hit = (m_inc != 32'd0) && (m_inc == 32'(LOOP2_THRESH));
   end

   // prev_pc doubles as the one-back PC; only the two-back entry lives here
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_d2 <= '0;
         m_cnt <= '0;
         hist2 <= '0;
      end else if (enter_boot) begin
         pc_d2 <= '0;
         m_cnt <= '0;
         hist2 <= '0;
      end else if (cur_st == S_RUN) begin
         pc_d2 <= prev_pc;
         m_cnt <= m_inc;
         if (hist2 != 2'd2) hist2 <= hist2 + 2'd1;
      end
   end
`else
   assign loop2_hit = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) cur_st <= S_IDLE;
      else       cur_st <= nxt_st;
   end

   always_comb begin
      nxt_st      = cur_st;
      core_reset  = 1'b0;
      core_enable = 1'b0;
      halted      = 1'b0;
      enter_boot  = 1'b0;
      case (cur_st)
         S_IDLE: begin
            core_reset = 1'b1;
            if (start) begin
               nxt_st     = S_BOOT;
               enter_boot = 1'b1;
            end
         end
         S_BOOT: begin
            core_reset = 1'b1;
            if (boot_cnt == 32'(BOOT_CYCLES - 1)) nxt_st = S_RUN;
         end
         S_RUN: begin
            core_enable = 1'b1;
            if (halt_any) nxt_st = S_HALT;
         end
         S_HALT: begin
            halted = 1'b1;
            if (start) begin
               nxt_st     = S_BOOT;
               enter_boot = 1'b1;
            end
         end
         default: nxt_st = S_IDLE;
      endcase
   end

   assign state = cur_st;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         boot_cnt    <= '0;
         cycle_count <= '0;
         instr_count <= '0;
         loop_pc     <= '0;
         halt_cause  <= '0;
         prev_pc     <= '0;
         prev_instr  <= '0;
         rep_cnt     <= '0;
         hist1       <= 1'b0;
      end else if (enter_boot) begin
         boot_cnt    <= '0;
         cycle_count <= '0;
         instr_count <= '0;
         loop_pc     <= '0;
         halt_cause  <= '0;
         prev_pc     <= '0;
         prev_instr  <= '0;
         rep_cnt     <= '0;
         hist1       <= 1'b0;
      end else if (cur_st == S_BOOT) begin
         boot_cnt <= boot_cnt + 32'd1;
      end else if (cur_st == S_RUN) begin
         cycle_count <= cyc_inc;
         if (instr_valid) instr_count <= ins_inc;
         prev_pc    <= pc_current;
         prev_instr <= instruction_current;
         rep_cnt    <= rep_inc;
         hist1      <= 1'b1;
         if (halt_any) begin
            halt_cause <= cause_sel;
            loop_pc    <= pc_current;
         end
      end
   end

endmodule

// File: doc/core_run_ctrl.md
CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

Interface
REQ-001 Parameter BOOT_CYCLES, default 2: cycles core_reset is held after start.
REQ-002 Parameter STABLE_THRESH, default 3: consecutive repeats of the same PC/instruction that declare a single-instruction halt loop.
REQ-003 Parameter LOOP2_THRESH, default 4: consecutive two-back PC matches that declare a two-instruction halt loop.
REQ-004 Parameter MAX_CYCLES, default 2000: RUN cycle budget before timeout.
REQ-005 clock  in  1: single clock; all state changes on the rising edge.
REQ-006 reset  in  1: asynchronous, active-high reset.
REQ-007 start  in  1: run request, sampled in IDLE and HALT.
REQ-008 halt_req  in  1: external halt request, sampled in RUN.
REQ-009 pc_current  in  32: datapath fetch PC.
REQ-010 instruction_current  in  32: datapath fetched instruction.
REQ-011 stall  in  1: datapath hazard stall.
REQ-012 core_reset  out  1: holds the datapath in reset.
REQ-013 core_enable  out  1: datapath advance enable.
REQ-014 state  out  2: FSM state (IDLE=0, BOOT=1, RUN=2, HALT=3).
REQ-015 halted  out  1: high in HALT.
REQ-016 halt_cause  out  2: 0 external, 1 single-instruction loop, 2 two-instruction loop, 3 timeout.
REQ-017 cycle_count  out  32: RUN cycles elapsed.
REQ-018 instr_count  out  32: valid instructions counted.
REQ-019 loop_pc  out  32: pc_current sampled in the cycle the halt was declared.

Function
REQ-020 IDLE: core_reset=1, core_enable=0; start=1 moves to BOOT; halt_req is ignored.
REQ-021 BOOT: core_reset=1, core_enable=0, lasting exactly BOOT_CYCLES cycles, then RUN; cycle_count, instr_count, loop_pc, halt_cause and all detector state clear on BOOT entry.
REQ-022 RUN: core_reset=0, core_enable=1; cycle_count increments every RUN cycle, including the cycle a halt is declared.
REQ-023 instr_count increments in a RUN cycle when instruction_current != 32'h00000013 and stall=0.
REQ-024 Both counters saturate at 32'hFFFFFFFF.
REQ-025 Single-loop detector: the repeat counter increments when pc_current and instruction_current equal the previous RUN cycle's values, and clears otherwise; it declares a halt when the incremented value equals STABLE_THRESH.
REQ-026 Two-loop detector: the match counter increments when pc_current equals the PC from two RUN cycles earlier, and clears otherwise; it declares a halt when the incremented value equals LOOP2_THRESH.
REQ-027 Comparisons in REQ-025 and REQ-026 are suppressed until one and two RUN cycles respectively have been recorded since BOOT.
REQ-028 Timeout is declared when the incremented cycle_count equals MAX_CYCLES.
REQ-029 Any declared halt moves RUN to HALT on the next edge and records halt_cause and loop_pc.
REQ-030 Simultaneous halt sources resolve in the priority order external > cause 1 > cause 2 > timeout.
REQ-031 HALT: core_enable=0, core_reset=0, halted=1; counters, halt_cause and loop_pc hold.
REQ-032 start=1 in HALT moves to BOOT; start in BOOT or RUN is ignored.

Reset
REQ-033 Asserting reset at any time, including mid-RUN, forces IDLE immediately: core_reset=1, core_enable=0, halted=0, halt_cause=0, cycle_count=0, instr_count=0, loop_pc=0, state=0, all detector history cleared.

Configuration
REQ-034 Macro RUN_CTRL_LOOP2_EN: when defined, the two-instruction detector is compiled in; when undefined, it and its PC history are absent, halt_cause=2 never occurs, and all other behaviour is unchanged.

Verification
REQ-035 Reset, then start pulse -> state 0->1, core_reset=1 for 2 cycles, then state=2, core_enable=1, counters 0.
REQ-036 In RUN, hold PC=0x28, instr=0x0000006F for 4 cycles -> HALT with cause 1, loop_pc=0x28, counters frozen.
REQ-037 With RUN_CTRL_LOOP2_EN, alternate PC 0x30/0x34 with distinct instructions -> HALT cause 2 on the 4th consecutive two-back match; without the macro -> no halt until timeout.
REQ-038 Feed 10 cycles: 3 NOPs, 2 stalled non-NOPs, 5 valid non-NOPs -> instr_count=5, cycle_count=10.
REQ-039 Vary PC each cycle with MAX_CYCLES=2000 -> HALT cause 3 with cycle_count=2000.
REQ-040 Assert halt_req in the same cycle a loop halt is declared -> cause 0; assert reset mid-RUN -> IDLE outputs immediately; start in HALT -> BOOT with cleared counters.
